// File: rtl/j17_prog_loader.sv
// ----------------------------------------------------------------------------
// j17_prog_loader
//   Boot-time program loader for the J17 core. This block is the write side of
//   the instruction memory that InstructionFetch reads. It takes a byte stream,
//   packs the bytes into big-endian 32-bit words and writes them to consecutive
//   imem word addresses, starting at 0. The core is held through cpu_hold until
//   a complete image has loaded.
//
//   Stream: N_hi, N_lo (16-bit word count), then 4*N data bytes (first byte of
//   each word -> wdata[31:24]), then one checksum byte when the checksum build
//   option is enabled.
//
//   Build option: `define J17_LOADER_CHECKSUM_EN to add a trailing checksum
//   byte. The 8-bit sum of every stream byte, including the checksum byte, must
//   be 0 mod 256 for the load to pass.
//
// Ports
//   clock        in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   1-cycle pulse that begins a load session (IDLE/ERR only)
//   rx_data      in   stream byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte (transfer = rx_valid & rx_ready)
//   imem_we      out  imem write strobe, 1 cycle per word
//   imem_addr    out  imem word address (holds between strobes)
//   imem_wdata   out  imem write data (holds between strobes)
//   cpu_hold     out  1 = core held; drops only after a successful load
//   busy         out  load session in progress
//   done         out  1-cycle pulse: image loaded OK
//   error        out  sticky fault flag, cleared by the next accepted start
//   words_loaded out  words written in this session
// ----------------------------------------------------------------------------
module j17_prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [63:0] CAPACITY = 64'd1 << ADDR_W;

`ifdef J17_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_DONE, S_ERR
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;

  logic [7:0]          r_nhi;
  logic [ADDR_W:0]     r_nwords;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_shift;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_words;
  logic                r_hold;
  logic                r_err;
`ifdef J17_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic [7:0]          w_sum_nxt;
`endif

  logic                w_xfer;
  logic                w_start_ok;
  logic [15:0]         w_n;
  logic                w_hdr_bad;
  logic                w_word_done;
  logic [ADDR_W:0]     w_words_inc;
  logic                w_last_word;

  assign w_xfer      = rx_valid & rx_ready;
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_n         = {r_nhi, rx_data};
  assign w_hdr_bad   = (w_n == 16'd0) || (64'(w_n) > CAPACITY);
  assign w_word_done = w_xfer && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
  // words_loaded doubles as the index of the word being assembled.
  assign w_words_inc = r_words + (ADDR_W+1)'(1);
  assign w_last_word = w_word_done && (w_words_inc == r_nwords);
`ifdef J17_LOADER_CHECKSUM_EN
  assign w_sum_nxt   = r_sum + rx_data;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_HDR_HI;
      S_HDR_HI: if (w_xfer) w_state_nxt = S_HDR_LO;
      S_HDR_LO: if (w_xfer) w_state_nxt = w_hdr_bad ? S_ERR : S_DATA;
`ifdef J17_LOADER_CHECKSUM_EN
      S_DATA:   if (w_last_word) w_state_nxt = S_CSUM;
      S_CSUM:   if (w_xfer) w_state_nxt = (w_sum_nxt == 8'd0) ? S_DONE : S_ERR;
`else
      S_DATA:   if (w_last_word) w_state_nxt = S_DONE;
`endif
      S_DONE:   w_state_nxt = S_IDLE;
      S_ERR:    if (start) w_state_nxt = S_HDR_HI;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_HDR_HI, S_HDR_LO, S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef J17_LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: header capture, word packing, write strobe, status flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_nhi      <= '0;
      r_nwords   <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_words    <= '0;
      r_hold     <= 1'b1;
      r_err      <= 1'b0;
`ifdef J17_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_we <= 1'b0;

      if (w_start_ok) begin
        r_err      <= 1'b0;
        r_hold     <= 1'b1;
        r_words    <= '0;
        r_byte_cnt <= '0;
`ifdef J17_LOADER_CHECKSUM_EN
        r_sum      <= '0;
`endif
      end

      if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
        r_err <= 1'b1;
      end

      // The core is released the cycle after the done pulse.
      if (r_state == S_DONE) begin
        r_hold <= 1'b0;
      end

      if (w_xfer) begin
`ifdef J17_LOADER_CHECKSUM_EN
        r_sum <= w_sum_nxt;
`endif
        case (r_state)
          S_HDR_HI: r_nhi <= rx_data;
          // Truncation is harmless: an oversize count is routed to ERR.
          S_HDR_LO: r_nwords <= (ADDR_W+1)'(w_n);
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], rx_data};
            if (r_byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wdata <= {r_shift, rx_data};
              r_words <= w_words_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_hold     = r_hold;
  assign error        = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_j17_prog_loader.sv
module tb_j17_prog_loader;

  localparam int unsigned AW  = 8;
  localparam int unsigned CAP = 1 << AW;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  j17_prog_loader #(.ADDR_W(AW)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observed writes and done pulses
  logic [AW+31:0] act_q[$];
  int             done_cnt;
  logic           we_at_done, hold_after, busy_after, prev_done;

  always @(negedge clock) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        hold_after = cpu_hold;
        busy_after = busy;
      end
      if (imem_we) act_q.push_back({imem_addr, imem_wdata});
      if (done) begin
        done_cnt++;
        we_at_done = imem_we;
      end
      prev_done = done;
    end
  end

  // Stimulus stream and reference expectations
  logic [7:0]     stim[$];
  logic [AW+31:0] exp_q[$];
  bit             exp_err, exp_done;
  int             exp_cons, exp_words;

  task automatic add_csum();
`ifdef J17_LOADER_CHECKSUM_EN
    int s = 0;
    foreach (stim[k]) s += int'(stim[k]);
    stim.push_back(8'((256 - (s % 256)) % 256));
`endif
  endtask

  task automatic build_random(input int n_hdr, input int n_words);
    stim.delete();
    stim.push_back(8'(n_hdr >> 8));
    stim.push_back(8'(n_hdr & 255));
    repeat (4 * n_words) stim.push_back(8'($urandom));
    add_csum();
  endtask

  task automatic build_fixed();
    stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    add_csum();
  endtask

  // Reference: derive the expected outcome directly from the stream rules.
  task automatic model();
    int n;
    n = int'(stim[0]) * 256 + int'(stim[1]);
    exp_q.delete();
    if (n == 0 || n > int'(CAP)) begin
      exp_err = 1; exp_done = 0; exp_cons = 2; exp_words = 0;
    end else begin
      for (int k = 0; k < n; k++)
        exp_q.push_back({AW'(k), stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]});
      exp_words = n;
      exp_cons  = 2 + 4 * n;
`ifdef J17_LOADER_CHECKSUM_EN
      begin
        int s = 0;
        exp_cons++;
        for (int k = 0; k < exp_cons; k++) s += int'(stim[k]);
        exp_err = (s % 256) != 0;
      end
`else
      exp_err = 0;
`endif
      exp_done = !exp_err;
    end
  endtask

  // Offer stim[0..limit-1]; stops early once the loader stops accepting.
  task automatic send(input int limit, input int gap, input int start_idx, output int consumed);
    int  i = 0;
    int  cyc = 0;
    int  budget = 20 * limit + 100;
    bit  did = 0;
    while (i < limit && cyc < budget) begin
      rx_data  = stim[i];
      rx_valid = ($urandom_range(99) >= gap);
      start    = (i == start_idx) && !did;
      if (start) did = 1;
      if (!rx_ready) break;
      if (rx_valid) i++;
      @(negedge clock);
      cyc++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    consumed = i;
    check("send_budget", 64'(cyc < budget), 64'd1);
  endtask

  task automatic run_load(input string name, input int gap, input int start_idx);
    int cons;
    int w;
    act_q.delete();
    done_cnt   = 0;
    we_at_done = 1'bx;
    hold_after = 1'bx;
    busy_after = 1'bx;
    model();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({name, ".start_busy"},  64'(busy), 64'd1);
    check({name, ".start_hold"},  64'(cpu_hold), 64'd1);
    check({name, ".start_err"},   64'(error), 64'd0);
    check({name, ".start_words"}, 64'(words_loaded), 64'd0);
    send(stim.size(), gap, start_idx, cons);
    check({name, ".consumed"}, 64'(cons), 64'(exp_cons));
    w = 0;
    while (w < 20 && busy) begin
      @(negedge clock);
      w++;
    end
    check({name, ".idle_budget"}, 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    check({name, ".error"},    64'(error), 64'(exp_err));
    check({name, ".done_cnt"}, 64'(done_cnt), 64'(exp_done));
    check({name, ".cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
    check({name, ".words"},    64'(words_loaded), 64'(exp_words));
    check({name, ".nwrites"},  64'(act_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
      check($sformatf("%s.write%0d", name, k), 64'(act_q[k]), 64'(exp_q[k]));
    if (exp_done) begin
      check({name, ".hold_after_done"}, 64'(hold_after), 64'd0);
      check({name, ".busy_after_done"}, 64'(busy_after), 64'd0);
`ifndef J17_LOADER_CHECKSUM_EN
      check({name, ".we_with_done"}, 64'(we_at_done), 64'd1);
`endif
    end
  endtask

  initial begin
    int cons;
    int n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst.rx_ready", 64'(rx_ready), 64'd0);
    check("rst.we",       64'(imem_we), 64'd0);
    check("rst.addr",     64'(imem_addr), 64'd0);
    check("rst.wdata",    64'(imem_wdata), 64'd0);
    check("rst.busy",     64'(busy), 64'd0);
    check("rst.done",     64'(done), 64'd0);
    check("rst.error",    64'(error), 64'd0);
    check("rst.words",    64'(words_loaded), 64'd0);
    check("rst.hold",     64'(cpu_hold), 64'd1);
    rst_n = 1'b1;
    @(negedge clock);

    // Bytes offered in IDLE are not consumed
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("idle.rx_ready", 64'(rx_ready), 64'd0);
      check("idle.busy",     64'(busy), 64'd0);
    end
    rx_valid = 1'b0;

    // Two-word image, full rate and with random gaps
    build_fixed();
    run_load("fixed", 0, -1);
    run_load("fixed_gap", 50, -1);

    // Random images, some with a start pulse landing mid-DATA
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 16);
      build_random(n, n);
      run_load($sformatf("rand%0d", t), $urandom_range(0, 60),
               (t % 2 == 1) ? $urandom_range(3, 4 * n) : -1);
    end

    // Boundary counts
    build_random(int'(CAP), int'(CAP));
    run_load("full", 20, -1);
    build_random(1, 1);
    run_load("one", 0, -1);
    build_random(0, 1);
    run_load("n0", 0, -1);
    build_random(int'(CAP) + 1, 1);
    run_load("nover", 0, -1);
    build_random(3, 3);
    run_load("after_err", 10, -1);

`ifdef J17_LOADER_CHECKSUM_EN
    build_fixed();
    stim[stim.size()-1] = stim[stim.size()-1] + 8'd1;
    run_load("bad_csum", 0, -1);
    build_fixed();
    run_load("csum_recover", 0, -1);
`endif

    // Asynchronous reset in the middle of DATA, then a clean load
    build_random(4, 4);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send(11, 0, -1, cons);
    check("midrst.consumed", 64'(cons), 64'd11);
    check("midrst.pre_words", 64'(words_loaded), 64'((11 - 2) / 4));
    #2 rst_n = 1'b0;
    #1;
    check("midrst.rx_ready", 64'(rx_ready), 64'd0);
    check("midrst.we",       64'(imem_we), 64'd0);
    check("midrst.addr",     64'(imem_addr), 64'd0);
    check("midrst.wdata",    64'(imem_wdata), 64'd0);
    check("midrst.busy",     64'(busy), 64'd0);
    check("midrst.done",     64'(done), 64'd0);
    check("midrst.error",    64'(error), 64'd0);
    check("midrst.words",    64'(words_loaded), 64'd0);
    check("midrst.hold",     64'(cpu_hold), 64'd1);
    @(negedge clock);
    rst_n = 1'b1;
    run_load("post_rst", 30, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
